// File: rtl/serial2parallel.sv
// serial2parallel: LSB-first 1-bit serial frame receiver.
// Optional frame checking with S2P_FRAME_CHECK_EN.
module serial2parallel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             serial_start,
  input  logic             serial_end,
  output logic [WIDTH-1:0] q,
  output logic             parallel_valid,
  output logic             busy,
  output logic             frame_error
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-2:0] shift, shift_n;
  logic [WIDTH-1:0] q_n;
  logic             pv_n;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == SHIFT);

`ifdef S2P_FRAME_CHECK_EN
  logic err_n;
  logic err_q;
  assign frame_error = err_q;
`else
  logic unused_end;
  assign unused_end  = serial_end;
  assign frame_error = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    q_n     = q;
    pv_n    = 1'b0;
`ifdef S2P_FRAME_CHECK_EN
    err_n   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (serial_start) begin
          shift_n[0] = d;
          cnt_n      = CW'(1);
          state_n    = SHIFT;
        end
`ifdef S2P_FRAME_CHECK_EN
        else if (serial_end) begin
          err_n = 1'b1;
        end
`endif
      end
      SHIFT: begin
        if (serial_start) begin
          // restart: this cycle is bit 0 of a new frame
          shift_n[0] = d;
          cnt_n      = CW'(1);
`ifdef S2P_FRAME_CHECK_EN
          err_n      = 1'b1;
`endif
        end
`ifdef S2P_FRAME_CHECK_EN
        else if (serial_end != last) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
`endif
        else if (last) begin
          q_n     = {d, shift};
          pv_n    = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          for (int i = 0; i < WIDTH - 1; i++) begin
            if (cnt == CW'(i)) shift_n[i] = d;
          end
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      shift          <= '0;
      q              <= '0;
      parallel_valid <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      shift          <= shift_n;
      q              <= q_n;
      parallel_valid <= pv_n;
    end
  end

`ifdef S2P_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_n;
  end
`endif

endmodule
